// File: rtl/mem_bus_bridge_pkg.sv
// mem_bus_bridge_pkg
//   Shared types and constants for the datapath-to-memory-bus bridge.
//   - state_e        : bridge FSM encoding (also exported on the debug port)
//   - DEFAULT_TIMEOUT: cycles allowed in ADDR or WAIT_R before an abort
//   - TIMEOUT_RDATA  : word returned to the datapath when a read is aborted
//   - is_busy()      : true while a bus transaction is outstanding
package mem_bus_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int          DEFAULT_TIMEOUT = 255;
  localparam logic [31:0] TIMEOUT_RDATA   = 32'h0;

  function automatic logic is_busy(input state_e s);
    return (s == ST_ADDR) || (s == ST_WAIT_R);
  endfunction

endpackage

// File: rtl/mem_bus_bridge_if.sv
// mem_bus_bridge_if
//   External memory bus between the bridge (master) and memory (slave).
//   Signals: bus_valid, bus_ready, bus_we, bus_addr, bus_wdata (request),
//            bus_rvalid, bus_rdata (read response).
//
// Handshake: a request transfers on a rising clk edge where bus_valid and
// bus_ready are both 1; while bus_valid=1 and bus_ready=0 the master keeps
// bus_we/bus_addr/bus_wdata stable and does not withdraw bus_valid (except
// when it abandons the access on timeout). A read response has no
// back-pressure: it is a single-cycle bus_rvalid pulse with bus_rdata, taken
// by the master only while it is waiting for that response.
interface mem_bus_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              bus_valid;
  logic              bus_ready;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_bus_bridge_sat_counter.sv
// sat_counter
//   Saturating up-counter used as the access timeout.
//   Ports: clk, reset (sync, active-low), clr_i (clear, wins over en_i),
//          en_i (count this cycle), tc_o (this enabled cycle is the MAX-th
//          consecutive one since the last clear).
module sat_counter #(
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // cnt_q holds the number of earlier enabled cycles, so MAX-1 marks the
  // MAX-th cycle; >= keeps the flag up once saturated.
  assign tc_o = en_i && (cnt_q >= W'(MAX - 1));

endmodule

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge
//   Turns the multicycle datapath's single memory port into valid/ready bus
//   requests and stalls the control unit until each access completes.
//   Ports:
//     clk, reset            : clock, synchronous active-low reset
//     cpu_en/cpu_we         : access request (held while stalled) / write flag
//     cpu_addr/cpu_wdata    : byte address / store data
//     cpu_rdata             : last read word, held until the next read ends
//     cpu_stall             : freeze request, low in the single release cycle
//     bus                   : memory bus, master side
//     err_timeout/err_misal.: sticky error flags, cleared only by reset
//     dbg_state             : current FSM state
module mem_bus_bridge
  import mem_bus_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  mem_bus_bridge_if.master  bus,
  output logic              err_timeout,
  output logic              err_misalign,
  output state_e            dbg_state
);

  state_e            state_q, state_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_misalign_q, err_misalign_d;
  logic              cnt_clr, cnt_en, cnt_tc;

  sat_counter #(.MAX(TIMEOUT)) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d        = state_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_wdata_d    = bus_wdata_q;
    cpu_rdata_d    = cpu_rdata_q;
    err_timeout_d  = err_timeout_q;
    err_misalign_d = err_misalign_q;
    cnt_en         = is_busy(state_q);
    cnt_clr        = !is_busy(state_q);

    case (state_q)
      ST_IDLE: begin
        if (cpu_en) begin
          bus_addr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
          bus_we_d    = cpu_we;
          bus_wdata_d = cpu_wdata;
          if (cpu_addr[1:0] != 2'b00) err_misalign_d = 1'b1;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        // An accept in the last allowed cycle beats the timeout.
        if (bus.bus_ready) begin
          cnt_clr = 1'b1;
          state_d = bus_we_q ? ST_DONE : ST_WAIT_R;
        end else if (cnt_tc) begin
          err_timeout_d = 1'b1;
          if (!bus_we_q) cpu_rdata_d = DATA_W'(TIMEOUT_RDATA);
          state_d = ST_DONE;
        end
      end
      ST_WAIT_R: begin
        // Responses are only sampled here, so an rvalid coinciding with the
        // accept cycle, or arriving after an abort/reset, is dropped.
        if (bus.bus_rvalid) begin
          cpu_rdata_d = bus.bus_rdata;
          state_d     = ST_DONE;
        end else if (cnt_tc) begin
          err_timeout_d = 1'b1;
          cpu_rdata_d   = DATA_W'(TIMEOUT_RDATA);
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= '0;
      bus_wdata_q    <= '0;
      cpu_rdata_q    <= '0;
      err_timeout_q  <= 1'b0;
      err_misalign_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_wdata_q    <= bus_wdata_d;
      cpu_rdata_q    <= cpu_rdata_d;
      err_timeout_q  <= err_timeout_d;
      err_misalign_q <= err_misalign_d;
    end
  end

  assign bus.bus_valid = (state_q == ST_ADDR);
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;

  // DONE is the one cycle the control FSM may advance; if cpu_en drops in
  // mid-access the bus transaction still finishes but nothing is frozen.
  assign cpu_stall    = cpu_en && (state_q != ST_DONE);
  assign cpu_rdata    = cpu_rdata_q;
  assign err_timeout  = err_timeout_q;
  assign err_misalign = err_misalign_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb_mem_bus_bridge
//   Directed scenarios followed by randomized accesses against a
//   transaction-level model of the bridge (latency formula, sticky flags and
//   an expected-read-data queue).
module tb_mem_bus_bridge;
  import mem_bus_bridge_pkg::*;

  localparam int TMO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cpu_en, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, err_timeout, err_misalign;
  state_e      dbg_state;

  mem_bus_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  mem_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_en       (cpu_en),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_stall    (cpu_stall),
    .bus          (bus_if),
    .err_timeout  (err_timeout),
    .err_misalign (err_misalign),
    .dbg_state    (dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata;
  logic        exp_tmo, exp_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Stall cycles from cpu_en rise to release: one IDLE cycle, the ADDR wait,
  // and for reads the response wait; an abort caps the stuck phase at TMO.
  function automatic int model_stall(input logic we, input int d, input int r);
    if (d >= TMO) return TMO + 1;
    if (we)       return d + 2;
    if (r >= TMO) return d + TMO + 2;
    return d + r + 3;
  endfunction

  function automatic int model_valid_cycles(input int d);
    return (d >= TMO) ? TMO : d + 1;
  endfunction

  // ---------------- driver ----------------
  // One access: memory accepts after d ADDR cycles and answers a read r
  // cycles into the response wait. early_rv also pulses a bogus rvalid in
  // the accept cycle. keep_en leaves cpu_en high for a back-to-back access.
  task automatic run_access(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int d, input int r, input logic early_rv,
                            input logic keep_en);
    int   stall_n, valid_n, wait_n;
    logic in_wait, fin, aborted;
    stall_n = 0; valid_n = 0; wait_n = 0; in_wait = 1'b0; fin = 1'b0;

    aborted = (d >= TMO) || (!we && (r >= TMO));
    if (addr[1:0] != 2'b00) exp_mis = 1'b1;
    if (aborted) exp_tmo = 1'b1;
    if (!we) exp_q.push_back(aborted ? 32'h0 : rdata);

    cpu_en = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    for (int cyc = 0; cyc < 64 && !fin; cyc++) begin
      bus_if.bus_ready  = bus_if.bus_valid && (valid_n == d);
      bus_if.bus_rvalid = in_wait && (wait_n == r);
      bus_if.bus_rdata  = bus_if.bus_rvalid ? rdata : $urandom;
      if (early_rv && bus_if.bus_ready) begin
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = ~rdata;
      end
      #1;
      if (bus_if.bus_valid) begin
        check("bus_addr", bus_if.bus_addr, {addr[31:2], 2'b00});
        check("bus_we", 32'(bus_if.bus_we), 32'(we));
        if (we) check("bus_wdata", bus_if.bus_wdata, wdata);
        valid_n++;
      end
      if (cpu_stall) begin
        stall_n++;
      end else begin
        fin = 1'b1;
        check("done_state", 32'(dbg_state), 32'(ST_DONE));
        if (!we) last_rdata = exp_q.pop_front();
        check("rdata_done", cpu_rdata, last_rdata);
        check("err_timeout", 32'(err_timeout), 32'(exp_tmo));
        check("err_misalign", 32'(err_misalign), 32'(exp_mis));
      end
      @(negedge clk);
      if (in_wait) wait_n++;
      else if (bus_if.bus_ready && !we) in_wait = 1'b1;
    end
    if (!fin) check("access_bound", 32'(0), 32'(1));
    check("stall_cycles", 32'(stall_n), 32'(model_stall(we, d, r)));
    check("valid_cycles", 32'(valid_n), 32'(model_valid_cycles(d)));
    bus_if.bus_ready  = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    #1;
    check("rdata_held", cpu_rdata, last_rdata);
    if (!keep_en) begin
      cpu_en = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    check({tag, "_valid"}, 32'(bus_if.bus_valid), 32'(0));
    check({tag, "_we"}, 32'(bus_if.bus_we), 32'(0));
    check({tag, "_addr"}, bus_if.bus_addr, 32'h0);
    check({tag, "_wdata"}, bus_if.bus_wdata, 32'h0);
    check({tag, "_rdata"}, cpu_rdata, 32'h0);
    check({tag, "_tmo"}, 32'(err_timeout), 32'(0));
    check({tag, "_mis"}, 32'(err_misalign), 32'(0));
    check({tag, "_stall"}, 32'(cpu_stall), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; cpu_en = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    bus_if.bus_ready = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = '0;
    last_rdata = '0; exp_tmo = 1'b0; exp_mis = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    @(negedge clk);

    // basic read, write with slow ready, back-to-back fetch then load
    run_access(1'b0, 32'h00000010, 32'h0, 32'h8C010004, 0, 0, 1'b0, 1'b0);
    run_access(1'b1, 32'h00000020, 32'hCAFEF00D, 32'h0, 4, 0, 1'b0, 1'b0);
    run_access(1'b0, 32'h00000100, 32'h0, 32'h11111111, 0, 1, 1'b0, 1'b1);
    run_access(1'b0, 32'h00000200, 32'h0, 32'h22222222, 2, 0, 1'b0, 1'b0);
    // rvalid in the accept cycle must be ignored
    run_access(1'b0, 32'h00000030, 32'h0, 32'h33333333, 0, 0, 1'b1, 1'b0);
    // misaligned read goes out aligned
    run_access(1'b0, 32'h00000013, 32'h0, 32'h44444444, 1, 0, 1'b0, 1'b0);
    // no read response at all
    run_access(1'b0, 32'h00000040, 32'h0, 32'h55555555, 0, 100, 1'b0, 1'b0);
    // flags persist across a clean access
    run_access(1'b0, 32'h00000044, 32'h0, 32'h66666666, 1, 2, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_access(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                 $urandom_range(0, 9), $urandom_range(0, 9),
                 ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end
    cpu_en = 1'b0;
    @(negedge clk);

    // reset while waiting for a response, then a late rvalid in IDLE
    cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h00000050; bus_if.bus_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_rst_state", 32'(dbg_state), 32'(ST_WAIT_R));
    bus_if.bus_ready = 1'b0;
    reset = 1'b0; cpu_en = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs("mid_rst");
    reset = 1'b1;
    bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'hDEADBEEF;
    @(negedge clk);
    bus_if.bus_rvalid = 1'b0;
    #1;
    check("late_rv_state", 32'(dbg_state), 32'(ST_IDLE));
    check("late_rv_rdata", cpu_rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_bridge.md
Name: mem_bus_bridge

Overview:
- Sits between the multicycle datapath's single memory port (address mux output, register-B write data, memory write strobe) and an external variable-latency memory bus.
- Converts each datapath access into a valid/ready request plus a read-response handshake.
- Asserts a stall that freezes the control FSM and the architectural enables (PC, IR, register file, MDR) until the access completes.
- Holds the read word stable so the IR and MDR capture it on the release cycle.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum cycles spent in ADDR or WAIT_R before the access is aborted.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- cpu_en  in  1  datapath requests a memory access; held high while cpu_stall=1.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  byte address from the IorD mux.
- cpu_wdata  in  DATA_W  store data from register B.
- cpu_rdata  out  DATA_W  read data, held until the next read completes.
- cpu_stall  out  1  freeze request to the control unit.
- bus_valid  out  1  request valid.
- bus_ready  in  1  memory accepts the request.
- bus_we  out  1  write flag of the request.
- bus_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2], 2'b00}.
- bus_wdata  out  DATA_W  write data.
- bus_rvalid  in  1  read response valid.
- bus_rdata  in  DATA_W  read response data.
- err_timeout  out  1  sticky; set when an access is aborted by timeout.
- err_misalign  out  1  sticky; set when cpu_addr[1:0] != 0 is accepted.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE; bus_valid=0; bus_we=0.
  - bus_addr=0, bus_wdata=0, cpu_rdata=0.
  - err_timeout=0, err_misalign=0; timeout counter=0.
  - Reset mid-transaction abandons the access; a late bus_rvalid arriving in IDLE is ignored.
- States: IDLE, ADDR, WAIT_R, DONE.
- IDLE:
  - If cpu_en=1: latch addr (aligned), we and wdata into the bus registers; go to ADDR.
  - If cpu_addr[1:0]!=0 when latching, set err_misalign; the access still proceeds aligned.
- ADDR:
  - bus_valid=1; the request stays stable until bus_ready.
  - On bus_ready=1: write goes to DONE; read goes to WAIT_R. Counter clears.
- WAIT_R:
  - bus_valid=0.
  - On bus_rvalid=1: cpu_rdata<=bus_rdata; go to DONE.
  - If bus_rvalid and bus_ready arrive in the same cycle as the ADDR→WAIT_R transition, that rvalid is not sampled; the response is taken only in WAIT_R.
- DONE: unconditionally go to IDLE.
- Stall:
  - cpu_stall = cpu_en & (state != DONE), combinational.
  - DONE is the single release cycle in which the control FSM advances.
  - A new cpu_en in the following IDLE cycle starts the next access; back-to-back accesses are supported.
- Latency, cpu_en rise to release cycle:
  - Write: 2 stall cycles minimum (IDLE, ADDR with ready).
  - Read: 3 stall cycles minimum (IDLE, ADDR, WAIT_R with rvalid).
- Timeout:
  - A counter increments each cycle in ADDR or WAIT_R.
  - When it reaches TIMEOUT: set err_timeout, drop bus_valid, cpu_rdata<=0 for reads, go to DONE.
  - The counter saturates and never wraps. Errors clear only on reset.
- cpu_en=0 while in ADDR or WAIT_R is a protocol violation. The bridge still completes the bus transaction; cpu_stall reads 0.
- Writes leave cpu_rdata unchanged.

Decomposition:
- Package mem_bus_bridge_pkg:
  - state encoding constants (IDLE=2'd0, ADDR=2'd1, WAIT_R=2'd2, DONE=2'd3);
  - default TIMEOUT;
  - the timeout read value 32'h0.
- One sub-module, sat_counter (clear, enable, terminal-count flag, width from TIMEOUT), instantiated for the timeout.

Test Plan:
- Read, bus_ready=1 in ADDR, rvalid one cycle later with bus_rdata=32'h8C010004, cpu_addr=32'h00000010:
  - bus_addr=32'h10;
  - cpu_stall high exactly 3 cycles;
  - cpu_rdata=32'h8C010004 in DONE and held after.
- Write cpu_addr=32'h20, cpu_wdata=32'hCAFEF00D, bus_ready delayed 4 cycles:
  - bus_valid, bus_addr and bus_wdata stable for 5 cycles;
  - cpu_stall high 6 cycles;
  - cpu_rdata unchanged.
- Back-to-back fetch then load: cpu_en held across the DONE cycle:
  - the second access enters ADDR 2 cycles after the first DONE;
  - both data words returned in order.
- Memory never asserts bus_rvalid, TIMEOUT=8:
  - err_timeout=1 after 8 WAIT_R cycles;
  - cpu_rdata=0; stall released; flag persists until reset.
- cpu_addr=32'h00000013 read: bus_addr=32'h10 and err_misalign=1.
- reset=0 asserted while in WAIT_R, then rvalid arrives in IDLE:
  - state IDLE, all outputs at reset values;
  - cpu_rdata stays 0.
